// File: rtl/conv_shift_acc.sv
`default_nettype none
// ============================================================================
// Module      : conv_shift_acc
// Description : Bit-serial shift-accumulator for conv crossbar partial sums.
//               One unsigned ADC_P-bit partial sum arrives per input
//               bit-plane, LSB plane first. Planes are shift-added into a
//               full-precision signed dot product. The MSB plane is
//               subtracted for two's-complement inputs. An optional ReLU is
//               applied, and the result is saturated to ACC_W bits and
//               offered on a valid/ready output.
// Ports       : clk, rst (async, active-high)
//               clear                      - synchronous abort to IDLE
//               psum_valid/psum/psum_ready - per-plane partial sum input
//               out_valid/out_data/out_ready/out_sat - result handshake
//               busy                       - accumulation or hold in progress
// Revision    : 1.0 - initial release
// ============================================================================
module conv_shift_acc #(
  parameter int ADC_P     = 6,
  parameter int IN_BITS   = 8,
  parameter int ACC_W     = 16,
  parameter int SIGNED_IN = 1,
  parameter int RELU_EN   = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             psum_valid,
  input  logic [ADC_P-1:0] psum,
  output logic             psum_ready,
  output logic             out_valid,
  output logic [ACC_W-1:0] out_data,
  input  logic             out_ready,
  output logic             out_sat,
  output logic             busy
);

  localparam int AW = ADC_P + IN_BITS + 1;                      // accumulator width
  localparam int CW = $clog2(IN_BITS);                          // plane counter width
  localparam int EW = ((AW > ACC_W) ? AW : ACC_W) + 1;          // saturation compare width

  localparam logic signed [EW-1:0] SAT_MAX = {{(EW-ACC_W+1){1'b0}}, {(ACC_W-1){1'b1}}};
  localparam logic signed [EW-1:0] SAT_MIN = {{(EW-ACC_W+1){1'b1}}, {(ACC_W-1){1'b0}}};
  localparam logic [CW-1:0]        LAST_PLANE = CW'(IN_BITS - 1);

  generate
    if (IN_BITS < 2 || IN_BITS > 16) begin : g_bad_in_bits
      $error("conv_shift_acc: IN_BITS must be in 2..16");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t                 state, state_next;
  logic signed [AW-1:0]   acc;
  logic [CW-1:0]          cnt;

  logic                   accept;
  logic                   last_plane;
  logic signed [AW-1:0]   term;
  logic signed [AW-1:0]   sum_add;
  logic signed [AW-1:0]   final_r;
  logic signed [AW-1:0]   relu_r;
  logic signed [EW-1:0]   ext_r;
  logic [ACC_W-1:0]       sat_data;
  logic                   sat_flag;
  logic signed [EW-1:0]   clamp_val;

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: next state and handshake outputs
  // --------------------------------------------------------------------------
  always_comb begin
    state_next = state;
    // Held low while rst is asserted even though the state already reads IDLE.
    psum_ready = 1'b0;
    busy       = 1'b0;
    accept     = 1'b0;
    if (!rst) begin
      psum_ready = (state != HOLD);
    end
    accept = psum_valid && psum_ready;
    busy   = (cnt != '0) || (state == HOLD);
    case (state)
      IDLE:    if (accept) state_next = ACCUM;
      ACCUM:   if (accept && last_plane) state_next = HOLD;
      HOLD:    if (out_valid && out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (clear) begin
      state_next = IDLE;
    end
  end

  // --------------------------------------------------------------------------
  // Datapath: weighted plane term, final-plane result, ReLU, saturation
  // --------------------------------------------------------------------------
  always_comb begin
    last_plane = (cnt == LAST_PLANE);
    term       = $signed({{(AW-ADC_P){1'b0}}, psum}) <<< cnt;
    sum_add    = acc + term;
    // Two's-complement inputs: the MSB plane carries negative weight.
    final_r    = (SIGNED_IN != 0) ? (acc - term) : sum_add;
    relu_r     = final_r;
    if (RELU_EN != 0 && final_r[AW-1]) begin
      relu_r = '0;
    end
    ext_r     = {{(EW-AW){relu_r[AW-1]}}, relu_r};
    clamp_val = ext_r;
    sat_flag  = 1'b0;
    if (ext_r > SAT_MAX) begin
      clamp_val = SAT_MAX;
      sat_flag  = 1'b1;
    end else if (ext_r < SAT_MIN) begin
      clamp_val = SAT_MIN;
      sat_flag  = 1'b1;
    end
    sat_data = clamp_val[ACC_W-1:0];
  end

  // --------------------------------------------------------------------------
  // Datapath registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc       <= '0;
      cnt       <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sat   <= 1'b0;
    end else if (clear) begin
      // out_data deliberately keeps its last value.
      acc       <= '0;
      cnt       <= '0;
      out_valid <= 1'b0;
      out_sat   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            acc <= $signed({{(AW-ADC_P){1'b0}}, psum});
            cnt <= CW'(1);
          end
        end
        ACCUM: begin
          if (accept) begin
            if (last_plane) begin
              acc       <= final_r;
              out_data  <= sat_data;
              out_sat   <= sat_flag;
              out_valid <= 1'b1;
            end else begin
              acc <= sum_add;
              cnt <= cnt + CW'(1);
            end
          end
        end
        HOLD: begin
          if (out_valid && out_ready) begin
            out_valid <= 1'b0;
            acc       <= '0;
            cnt       <= '0;
          end
        end
        default: begin
          acc <= '0;
          cnt <= '0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_conv_shift_acc.sv
`default_nettype none
// ============================================================================
// Module      : tb_conv_shift_acc
// Description : Directed self-checking bench for conv_shift_acc. Four
//               instances share one stimulus stream:
//                 u   : unsigned planes, ReLU on, 16-bit output
//                 s   : signed planes,   ReLU on, 16-bit output
//                 nr  : signed planes,   ReLU off, 16-bit output
//                 st  : unsigned planes, ReLU on, 12-bit output
// Revision    : 1.0 - initial release
// ============================================================================
module tb_conv_shift_acc;

  logic       clk = 1'b0;
  logic       rst;
  logic       clear;
  logic       psum_valid;
  logic [5:0] psum;
  logic       out_ready;

  logic        ready_u, valid_u, sat_u, busy_u;
  logic [15:0] data_u;
  logic        ready_s, valid_s, sat_s, busy_s;
  logic [15:0] data_s;
  logic        ready_nr, valid_nr, sat_nr, busy_nr;
  logic [15:0] data_nr;
  logic        ready_st, valid_st, sat_st, busy_st;
  logic [11:0] data_st;

  int chk_cnt  = 0;
  int pass_cnt = 0;

  always #5 clk = ~clk;

  conv_shift_acc #(.ADC_P(6), .IN_BITS(8), .ACC_W(16), .SIGNED_IN(0), .RELU_EN(1)) dut_u (
    .clk(clk), .rst(rst), .clear(clear), .psum_valid(psum_valid), .psum(psum),
    .psum_ready(ready_u), .out_valid(valid_u), .out_data(data_u),
    .out_ready(out_ready), .out_sat(sat_u), .busy(busy_u));

  conv_shift_acc #(.ADC_P(6), .IN_BITS(8), .ACC_W(16), .SIGNED_IN(1), .RELU_EN(1)) dut_s (
    .clk(clk), .rst(rst), .clear(clear), .psum_valid(psum_valid), .psum(psum),
    .psum_ready(ready_s), .out_valid(valid_s), .out_data(data_s),
    .out_ready(out_ready), .out_sat(sat_s), .busy(busy_s));

  conv_shift_acc #(.ADC_P(6), .IN_BITS(8), .ACC_W(16), .SIGNED_IN(1), .RELU_EN(0)) dut_nr (
    .clk(clk), .rst(rst), .clear(clear), .psum_valid(psum_valid), .psum(psum),
    .psum_ready(ready_nr), .out_valid(valid_nr), .out_data(data_nr),
    .out_ready(out_ready), .out_sat(sat_nr), .busy(busy_nr));

  conv_shift_acc #(.ADC_P(6), .IN_BITS(8), .ACC_W(12), .SIGNED_IN(0), .RELU_EN(1)) dut_st (
    .clk(clk), .rst(rst), .clear(clear), .psum_valid(psum_valid), .psum(psum),
    .psum_ready(ready_st), .out_valid(valid_st), .out_data(data_st),
    .out_ready(out_ready), .out_sat(sat_st), .busy(busy_st));

  // Feed n planes of a constant value; optional one-cycle gap after each.
  // Returns at the falling edge after the last accepting clock edge.
  task automatic feed(input int n, input logic [5:0] val, input bit gaps);
    bit rdy_ok = 1'b1;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      psum_valid = 1'b1;
      psum       = val;
      if (!ready_u) rdy_ok = 1'b0;
      @(posedge clk);
      if (gaps) begin
        @(negedge clk);
        psum_valid = 1'b0;
        psum       = 6'h2A;
        @(posedge clk);
      end
    end
    @(negedge clk);
    psum_valid = 1'b0;
    chk_cnt++;
    if (!rdy_ok) $display("FAIL feed_ready: psum_ready was 0 while feeding, required 1");
    else pass_cnt++;
  endtask

  // Complete the output handshake and confirm the block released the result.
  task automatic take_result(input logic [15:0] exp_data_u);
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    chk_cnt++;
    if (valid_u !== 1'b0 || busy_u !== 1'b0 || ready_u !== 1'b1)
      $display("FAIL handoff: valid=%b busy=%b ready=%b, required 0 0 1", valid_u, busy_u, ready_u);
    else pass_cnt++;
    chk_cnt++;
    if (data_u !== exp_data_u)
      $display("FAIL data_retained: out_data=%0d, required %0d", data_u, exp_data_u);
    else pass_cnt++;
  endtask

  task automatic test_reset();
    rst = 1'b1; clear = 1'b0; psum_valid = 1'b0; psum = '0; out_ready = 1'b0;
    @(negedge clk);
    chk_cnt++;
    if (ready_u !== 1'b0 || valid_u !== 1'b0 || data_u !== 16'd0 || sat_u !== 1'b0 || busy_u !== 1'b0)
      $display("FAIL reset_state: ready=%b valid=%b data=%h sat=%b busy=%b, required all 0",
               ready_u, valid_u, data_u, sat_u, busy_u);
    else pass_cnt++;
    rst = 1'b0;
    @(negedge clk);
    chk_cnt++;
    if (ready_u !== 1'b1 || busy_u !== 1'b0)
      $display("FAIL idle_after_reset: ready=%b busy=%b, required 1 0", ready_u, busy_u);
    else pass_cnt++;
  endtask

  task automatic test_ones();
    feed(8, 6'd1, 1'b0);
    chk_cnt++;
    if (valid_u !== 1'b1 || data_u !== 16'd255 || sat_u !== 1'b0)
      $display("FAIL ones_unsigned: valid=%b data=%0d sat=%b, required 1 255 0", valid_u, data_u, sat_u);
    else pass_cnt++;
    chk_cnt++;
    if (data_s !== 16'd0 || sat_s !== 1'b0)
      $display("FAIL ones_signed_relu: data=%h sat=%b, required 0000 0", data_s, sat_s);
    else pass_cnt++;
    chk_cnt++;
    if (data_nr !== 16'hFFFF)
      $display("FAIL ones_signed_norelu: data=%h, required ffff", data_nr);
    else pass_cnt++;
    chk_cnt++;
    if (ready_u !== 1'b0 || busy_u !== 1'b1)
      $display("FAIL hold_flags: ready=%b busy=%b, required 0 1", ready_u, busy_u);
    else pass_cnt++;
    take_result(16'd255);
  endtask

  task automatic test_signed_63();
    feed(8, 6'd63, 1'b0);
    chk_cnt++;
    if (valid_s !== 1'b1 || data_s !== 16'd0 || sat_s !== 1'b0)
      $display("FAIL s63_relu: valid=%b data=%h sat=%b, required 1 0000 0", valid_s, data_s, sat_s);
    else pass_cnt++;
    chk_cnt++;
    if (data_nr !== 16'hFFC1 || sat_nr !== 1'b0)
      $display("FAIL s63_norelu: data=%h sat=%b, required ffc1 0", data_nr, sat_nr);
    else pass_cnt++;
    chk_cnt++;
    if (data_u !== 16'd16065 || sat_u !== 1'b0)
      $display("FAIL u63_wide: data=%0d sat=%b, required 16065 0", data_u, sat_u);
    else pass_cnt++;
    chk_cnt++;
    if (data_st !== 12'h7FF || sat_st !== 1'b1)
      $display("FAIL u63_saturate: data=%h sat=%b, required 7ff 1", data_st, sat_st);
    else pass_cnt++;
    take_result(16'd16065);
  endtask

  task automatic test_backpressure();
    bit stable_ok = 1'b1;
    feed(8, 6'd2, 1'b0);
    // Offer the next vector's plane 0 while the result is still held.
    psum_valid = 1'b1;
    psum       = 6'd5;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (valid_u !== 1'b1 || data_u !== 16'd510 || ready_u !== 1'b0 || busy_u !== 1'b1)
        stable_ok = 1'b0;
    end
    chk_cnt++;
    if (!stable_ok)
      $display("FAIL bp_hold: valid=%b data=%0d ready=%b, required 1 510 0 for 5 cycles",
               valid_u, data_u, ready_u);
    else pass_cnt++;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    chk_cnt++;
    if (valid_u !== 1'b0 || ready_u !== 1'b1 || busy_u !== 1'b0)
      $display("FAIL bp_handoff: valid=%b ready=%b busy=%b, required 0 1 0", valid_u, ready_u, busy_u);
    else pass_cnt++;
    @(posedge clk);
    @(negedge clk);
    psum_valid = 1'b0;
    chk_cnt++;
    if (busy_u !== 1'b1)
      $display("FAIL bp_plane0_accept: busy=%b, required 1", busy_u);
    else pass_cnt++;
    feed(7, 6'd5, 1'b0);
    chk_cnt++;
    if (valid_u !== 1'b1 || data_u !== 16'd1275 || data_nr !== 16'hFFFB)
      $display("FAIL bp_next_vector: valid=%b u=%0d nr=%h, required 1 1275 fffb", valid_u, data_u, data_nr);
    else pass_cnt++;
    take_result(16'd1275);
  endtask

  task automatic test_stall();
    feed(8, 6'd63, 1'b1);
    chk_cnt++;
    if (valid_u !== 1'b1 || data_u !== 16'd16065 || data_nr !== 16'hFFC1)
      $display("FAIL stall_result: valid=%b u=%0d nr=%h, required 1 16065 ffc1", valid_u, data_u, data_nr);
    else pass_cnt++;
    chk_cnt++;
    if (data_st !== 12'h7FF || sat_st !== 1'b1)
      $display("FAIL stall_saturate: data=%h sat=%b, required 7ff 1", data_st, sat_st);
    else pass_cnt++;
    take_result(16'd16065);
  endtask

  task automatic test_clear();
    feed(4, 6'd63, 1'b0);
    @(negedge clk);
    clear = 1'b1; psum_valid = 1'b1; psum = 6'd63;
    @(posedge clk);
    @(negedge clk);
    clear = 1'b0; psum_valid = 1'b0;
    chk_cnt++;
    if (busy_u !== 1'b0 || valid_u !== 1'b0)
      $display("FAIL clear_accum: busy=%b valid=%b, required 0 0", busy_u, valid_u);
    else pass_cnt++;
    feed(8, 6'd1, 1'b0);
    chk_cnt++;
    if (valid_u !== 1'b1 || data_u !== 16'd255 || data_nr !== 16'hFFFF)
      $display("FAIL clear_fresh: valid=%b u=%0d nr=%h, required 1 255 ffff", valid_u, data_u, data_nr);
    else pass_cnt++;
    take_result(16'd255);
    // Clear while holding a saturated result: flags drop, data stays.
    feed(8, 6'd63, 1'b0);
    clear = 1'b1;
    @(posedge clk);
    @(negedge clk);
    clear = 1'b0;
    chk_cnt++;
    if (valid_st !== 1'b0 || sat_st !== 1'b0 || data_st !== 12'h7FF || busy_st !== 1'b0)
      $display("FAIL clear_hold: valid=%b sat=%b data=%h busy=%b, required 0 0 7ff 0",
               valid_st, sat_st, data_st, busy_st);
    else pass_cnt++;
  endtask

  task automatic test_async_reset();
    feed(3, 6'd63, 1'b0);
    #2 rst = 1'b1;
    #1;
    chk_cnt++;
    if (valid_u !== 1'b0 || busy_u !== 1'b0 || data_u !== 16'd0 || ready_u !== 1'b0)
      $display("FAIL async_reset: valid=%b busy=%b data=%0d ready=%b, required 0 0 0 0",
               valid_u, busy_u, data_u, ready_u);
    else pass_cnt++;
    @(negedge clk);
    rst = 1'b0;
    feed(8, 6'd2, 1'b0);
    chk_cnt++;
    if (valid_u !== 1'b1 || data_u !== 16'd510 || sat_u !== 1'b0)
      $display("FAIL post_reset: valid=%b data=%0d sat=%b, required 1 510 0", valid_u, data_u, sat_u);
    else pass_cnt++;
    take_result(16'd510);
  endtask

  initial begin
    test_reset();
    test_ones();
    test_signed_63();
    test_backpressure();
    test_stall();
    test_clear();
    test_async_reset();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
